// File: rtl/traffic_light_pkg.sv
// Shared state encoding and lamp patterns for the highway/farm-road controller.
package traffic_light_pkg;

   typedef enum logic [2:0] {
      HG_FR  = 3'd0,
      HY_FR  = 3'd1,
      HR_FR1 = 3'd2,
      HR_FG  = 3'd3,
      HR_FY  = 3'd4,
      HR_FR2 = 3'd5
   } state_e;

   localparam logic [2:0] LIGHT_RED    = 3'b100;
   localparam logic [2:0] LIGHT_YELLOW = 3'b010;
   localparam logic [2:0] LIGHT_GREEN  = 3'b001;

endpackage

// File: rtl/traffic_light_sensor_sync.sv
// Two-flop synchronizer for the asynchronous farm-road vehicle sensor.
module traffic_light_sensor_sync (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/traffic_light.sv
// Highway/farm-road intersection controller (Moore FSM, highway green by default).
// Define SENSOR_SYNC_EN to pass the sensor through a 2-flop synchronizer.
module traffic_light
   import traffic_light_pkg::*;
#(
   parameter int unsigned HWY_MIN_GREEN  = 10,
   parameter int unsigned YELLOW_CYCLES  = 3,
   parameter int unsigned ALL_RED_CYCLES = 2,
   parameter int unsigned FARM_MAX_GREEN = 10,
   parameter int unsigned CNT_W          = 8
) (
   output logic [2:0] light_highway,
   output logic [2:0] light_farm,
   input  logic       sensor,
   input  logic       clk,
   input  logic       rst_n
);

   localparam logic [CNT_W-1:0] HWY_LAST  = CNT_W'(HWY_MIN_GREEN - 1);
   localparam logic [CNT_W-1:0] YEL_LAST  = CNT_W'(YELLOW_CYCLES - 1);
   localparam logic [CNT_W-1:0] RED_LAST  = CNT_W'(ALL_RED_CYCLES - 1);
   localparam logic [CNT_W-1:0] FARM_LAST = CNT_W'(FARM_MAX_GREEN - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sensor_s;

`ifdef SENSOR_SYNC_EN
   traffic_light_sensor_sync u_sensor_sync (
      .clk (clk),
      .rst (rst_n),
      .d   (sensor),
      .q   (sensor_s)
   );
`else
   assign sensor_s = sensor;
`endif

   // Highway counter saturates so a late request is served without waiting for a wrap.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CNT_W'(1);
      case (state_q)
         HG_FR: begin
            if (cnt_q >= HWY_LAST) begin
               cnt_d = HWY_LAST;
               if (sensor_s) state_d = HY_FR;
            end
         end
         HY_FR:  if (cnt_q == YEL_LAST) state_d = HR_FR1;
         HR_FR1: if (cnt_q == RED_LAST) state_d = HR_FG;
         HR_FG:  if (!sensor_s || cnt_q == FARM_LAST) state_d = HR_FY;
         HR_FY:  if (cnt_q == YEL_LAST) state_d = HR_FR2;
         HR_FR2: if (cnt_q == RED_LAST) state_d = HG_FR;
         default: state_d = HG_FR;
      endcase
      if (state_d != state_q) cnt_d = '0;
   end

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         state_q <= HG_FR;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      light_highway = LIGHT_RED;
      light_farm    = LIGHT_RED;
      case (state_q)
         HG_FR:   light_highway = LIGHT_GREEN;
         HY_FR:   light_highway = LIGHT_YELLOW;
         HR_FG:   light_farm    = LIGHT_GREEN;
         HR_FY:   light_farm    = LIGHT_YELLOW;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_traffic_light.sv
// Scoreboard bench for traffic_light: phase-table reference model feeds an expected-lamp queue.
module tb_traffic_light;

   localparam int MIN_G = 10;
   localparam int YEL   = 3;
   localparam int ARED  = 2;
   localparam int MAX_F = 10;
`ifdef SENSOR_SYNC_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 0;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic       sensor;
   logic [2:0] lh, lf;

   traffic_light #(
      .HWY_MIN_GREEN  (MIN_G),
      .YELLOW_CYCLES  (YEL),
      .ALL_RED_CYCLES (ARED),
      .FARM_MAX_GREEN (MAX_F),
      .CNT_W          (8)
   ) dut (
      .light_highway (lh),
      .light_farm    (lf),
      .sensor        (sensor),
      .clk           (clk),
      .rst_n         (rst_n)
   );

   always #10 clk = ~clk;

   logic [5:0] exp_q[$];
   int n_cmp = 0;
   int n_bad = 0;

   // Reference: phase index into a fixed lamp table, plus cycles spent in that phase.
   logic [2:0] hw_tab [6] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100};
   logic [2:0] fm_tab [6] = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100};
   int phase;
   int age;
   bit hist[$];

   function automatic bit phase_done(input int ph, input int a, input bit s);
      case (ph)
         0:       return (a >= MIN_G - 1) && s;
         1, 4:    return a >= YEL - 1;
         2, 5:    return a >= ARED - 1;
         3:       return !s || (a >= MAX_F - 1);
         default: return 1'b1;
      endcase
   endfunction

   task automatic model_reset();
      phase = 0;
      age   = 0;
      hist.delete();
      for (int i = 0; i < LAT; i++) hist.push_back(1'b0);
   endtask

   task automatic model_clock(input bit s);
      bit eff;
      hist.push_back(s);
      eff = hist.pop_front();
      if (phase_done(phase, age, eff)) begin
         phase = (phase + 1) % 6;
         age   = 0;
      end else begin
         age = age + 1;
      end
   endtask

   // One clock: drive inputs just after the falling edge, predict lamps after the next rising edge.
   task automatic step(input bit r, input bit s);
      @(negedge clk);
      #1;
      rst_n  = r;
      sensor = s;
      if (r) model_reset();
      else   model_clock(s);
      exp_q.push_back({hw_tab[phase], fm_tab[phase]});
   endtask

   // Reset raised mid-high-phase: no rising edge occurs before the next sample.
   task automatic async_reset();
      @(negedge clk);
      #1;
      @(posedge clk);
      #5;
      rst_n = 1'b1;
      model_reset();
      exp_q.push_back({3'b001, 3'b100});
   endtask

   initial begin : monitor
      logic [5:0] e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if ({lh, lf} !== e) begin
               n_bad++;
               $display("FAIL lamps t=%0t: got hwy=%b farm=%b, want hwy=%b farm=%b",
                        $time, lh, lf, e[5:3], e[2:0]);
            end
            n_cmp++;
            if (lh !== 3'b100 && lf !== 3'b100) begin
               n_bad++;
               $display("FAIL both_non_red t=%0t: got hwy=%b farm=%b, want one road 100",
                        $time, lh, lf);
            end
         end
      end
   end

   initial begin : watchdog
      #2ms;
      $display("FAIL watchdog: simulation still running at %0t, want finish", $time);
      $fatal(1, "timeout");
   end

   initial begin : stim
      int n;
      bit s;
      rst_n  = 1'b1;
      sensor = 1'b0;
      model_reset();

      // Reset held, then quiet highway
      repeat (20) step(1'b1, 1'b0);
      repeat (500) step(1'b0, 1'b0);

      // Request three cycles after reset release
      repeat (2) step(1'b1, 1'b0);
      repeat (3) step(1'b0, 1'b0);
      repeat (25) step(1'b0, 1'b1);

      // Sensor held high: repeated max-length farm phases
      repeat (600) step(1'b0, 1'b1);

      // Drop sensor after four cycles of farm green
      for (int i = 0; i < 100 && phase != 3; i++) step(1'b0, 1'b1);
      repeat (3) step(1'b0, 1'b1);
      repeat (12) step(1'b0, 1'b0);

      // Asynchronous reset during farm green
      for (int i = 0; i < 100 && phase != 3; i++) step(1'b0, 1'b1);
      step(1'b0, 1'b1);
      async_reset();
      repeat (3) step(1'b1, 1'b1);

      // Random sensor bursts with occasional resets
      repeat (120) begin
         s = 1'($urandom_range(0, 1));
         n = $urandom_range(1, 25);
         if ($urandom_range(0, 19) == 0) begin
            async_reset();
            step(1'b1, s);
         end
         repeat (n) step(1'b0, s);
      end

      @(negedge clk);
      #2;
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: got %0d unchecked entries, want 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
